// File: rtl/dram_cmd_pkg.sv
// Shared definitions for the DRAM command buffer.
// Holds the command field widths and the packed command record
// {addr, rnw, wr_data, wr_be} (195 bits) stored in the FIFO.
package dram_cmd_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 144;
  localparam int unsigned BE_W   = 18;
  localparam int unsigned CMD_W  = ADDR_W + 1 + DATA_W + BE_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
  } dram_cmd_t;

endpackage

// File: rtl/dram_cmd_ram.sv
// Command storage for dram_cmd_buffer.
// DEPTH x dram_cmd_t simple dual-port memory: synchronous write,
// asynchronous read, no reset.
//   dram_clk : write clock
//   we       : write enable
//   waddr    : write address
//   wdata    : command written at waddr
//   raddr    : read address
//   rdata    : command stored at raddr (combinational)
module dram_cmd_ram
  import dram_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          dram_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  dram_cmd_t     wdata,
  input  logic [AW-1:0] raddr,
  output dram_cmd_t     rdata
);

  dram_cmd_t mem [DEPTH];

  always_ff @(posedge dram_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dram_cmd_buffer.sv
// DRAM command buffer: FIFO between an upstream command source and the
// DRAM controller.
//   dram_clk / dram_rst          : clock, async active-high reset
//   in_cmd_addr/rnw/valid        : incoming command (pushed whenever valid)
//   in_wr_data / in_wr_be        : incoming write payload
//   in_cmd_ack                   : registered, upstream may keep issuing
//   out_cmd_addr/rnw/valid       : registered command to controller
//   out_wr_data / out_wr_be      : registered write payload
//   out_fifo_ready               : controller accepts a command this cycle
//   fill_level                   : current entry count
//   overflow                     : sticky, a command was dropped
module dram_cmd_buffer
  import dram_cmd_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ACK_SLACK = 2
) (
  input  logic                     dram_clk,
  input  logic                     dram_rst,
  input  logic [ADDR_W-1:0]        in_cmd_addr,
  input  logic                     in_cmd_rnw,
  input  logic                     in_cmd_valid,
  input  logic [DATA_W-1:0]        in_wr_data,
  input  logic [BE_W-1:0]          in_wr_be,
  output logic                     in_cmd_ack,
  output logic [ADDR_W-1:0]        out_cmd_addr,
  output logic                     out_cmd_rnw,
  output logic                     out_cmd_valid,
  output logic [DATA_W-1:0]        out_wr_data,
  output logic [BE_W-1:0]          out_wr_be,
  input  logic                     out_fifo_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ACK_LIMIT = CW'(DEPTH - ACK_SLACK - 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  dram_cmd_t     in_cmd;
  dram_cmd_t     head_cmd;

  assign in_cmd = '{addr: in_cmd_addr, rnw: in_cmd_rnw,
                    wr_data: in_wr_data, wr_be: in_wr_be};

  // A full FIFO still accepts a push when a pop frees the head slot in the
  // same cycle; the head is read asynchronously before the write lands.
  always_comb begin
    pop        = (count != '0) && out_fifo_ready;
    push       = in_cmd_valid && ((count != FULL_CNT) || pop);
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  dram_cmd_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .dram_clk (dram_clk),
    .we       (push),
    .waddr    (wr_ptr),
    .wdata    (in_cmd),
    .raddr    (rd_ptr),
    .rdata    (head_cmd)
  );

  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_cmd_ack    <= 1'b0;
      overflow      <= 1'b0;
      out_cmd_valid <= 1'b0;
      out_cmd_addr  <= '0;
      out_cmd_rnw   <= 1'b0;
      out_wr_data   <= '0;
      out_wr_be     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      in_cmd_ack <= (count_next <= ACK_LIMIT);
      if (in_cmd_valid && !push) overflow <= 1'b1;
      out_cmd_valid <= pop;
      if (pop) begin
        out_cmd_addr <= head_cmd.addr;
        out_cmd_rnw  <= head_cmd.rnw;
        out_wr_data  <= head_cmd.wr_data;
        out_wr_be    <= head_cmd.wr_be;
      end
    end
  end

  assign fill_level = count;

endmodule

// File: tb/tb_dram_cmd_buffer.sv
module tb_dram_cmd_buffer;
  import dram_cmd_pkg::*;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned ACK_SLACK = 2;

  logic               dram_clk = 1'b0;
  logic               dram_rst = 1'b1;
  logic [ADDR_W-1:0]  in_cmd_addr = '0;
  logic               in_cmd_rnw = 1'b0;
  logic               in_cmd_valid = 1'b0;
  logic [DATA_W-1:0]  in_wr_data = '0;
  logic [BE_W-1:0]    in_wr_be = '0;
  logic               in_cmd_ack;
  logic [ADDR_W-1:0]  out_cmd_addr;
  logic               out_cmd_rnw;
  logic               out_cmd_valid;
  logic [DATA_W-1:0]  out_wr_data;
  logic [BE_W-1:0]    out_wr_be;
  logic               out_fifo_ready = 1'b0;
  logic [4:0]         fill_level;
  logic               overflow;

  dram_cmd_buffer #(
    .DEPTH     (DEPTH),
    .ACK_SLACK (ACK_SLACK)
  ) dut (
    .dram_clk       (dram_clk),
    .dram_rst       (dram_rst),
    .in_cmd_addr    (in_cmd_addr),
    .in_cmd_rnw     (in_cmd_rnw),
    .in_cmd_valid   (in_cmd_valid),
    .in_wr_data     (in_wr_data),
    .in_wr_be       (in_wr_be),
    .in_cmd_ack     (in_cmd_ack),
    .out_cmd_addr   (out_cmd_addr),
    .out_cmd_rnw    (out_cmd_rnw),
    .out_cmd_valid  (out_cmd_valid),
    .out_wr_data    (out_wr_data),
    .out_wr_be      (out_wr_be),
    .out_fifo_ready (out_fifo_ready),
    .fill_level     (fill_level),
    .overflow       (overflow)
  );

  always #5 dram_clk = ~dram_clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  dram_cmd_t   sb_q[$];
  int unsigned m_count = 0;
  logic        m_ovf = 1'b0;
  dram_cmd_t   last_out = '0;
  int unsigned pulses = 0;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        r;
    logic [17:0] b;
    logic        rdy;
    logic [4:0]  exp_fill;
    logic        exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] data_of(input logic [31:0] a);
    return {a, 4'h5, a, 4'ha, a, 4'h3, a, 4'hc};
  endfunction

  // Drive one cycle of stimulus, advance the model, then check the DUT
  // 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic r,
                     input logic [143:0] d, input logic [17:0] b, input logic rdy);
    logic      m_pop;
    logic      m_acc;
    dram_cmd_t act;
    dram_cmd_t exp;
    in_cmd_valid   = v;
    in_cmd_addr    = a;
    in_cmd_rnw     = r;
    in_wr_data     = d;
    in_wr_be       = b;
    out_fifo_ready = rdy;
    m_pop = (m_count != 0) && rdy;
    m_acc = v && ((m_count != DEPTH) || m_pop);
    if (m_acc) sb_q.push_back('{addr: a, rnw: r, wr_data: d, wr_be: b});
    if (v && !m_acc) m_ovf = 1'b1;
    m_count = m_count + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
    @(posedge dram_clk);
    #1;
    act = '{addr: out_cmd_addr, rnw: out_cmd_rnw, wr_data: out_wr_data, wr_be: out_wr_be};
    chk("out_valid", 256'(out_cmd_valid), 256'(m_pop));
    chk("fill_level", 256'(fill_level), 256'(m_count));
    chk("ack", 256'(in_cmd_ack), 256'(m_count <= DEPTH - ACK_SLACK - 1));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    if (out_cmd_valid) begin
      pulses++;
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 256'(1), 256'(0));
      end else begin
        exp = sb_q.pop_front();
        chk("out_cmd", 256'(act), 256'(exp));
        last_out = exp;
      end
    end else begin
      chk("out_hold", 256'(act), 256'(last_out));
    end
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, '0, 1'b0, '0, '0, rdy);
  endtask

  task automatic push_rand(input logic r, input logic rdy);
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    cyc(1'b1, $urandom, r, t[143:0], 18'($urandom), rdy);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 18'h3FFFF, 1'b1, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 18'h0,     1'b1, 5'd0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0200, 1'b1, 18'h00001, 1'b0, 5'd1, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0300, 1'b0, 18'h2AAAA, 1'b0, 5'd2, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0400, 1'b1, 18'h15555, 1'b1, 5'd2, 1'b1};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 18'h0,     1'b1, 5'd1, 1'b1};
    vecs[6] = '{1'b0, 32'h0,         1'b0, 18'h0,     1'b0, 5'd1, 1'b0};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 18'h0,     1'b1, 5'd0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 18'h0,     1'b1, 5'd0, 1'b0};

    // Reset state
    #22;
    chk("rst_valid", 256'(out_cmd_valid), 256'(0));
    chk("rst_fill", 256'(fill_level), 256'(0));
    chk("rst_ack", 256'(in_cmd_ack), 256'(0));
    chk("rst_ovf", 256'(overflow), 256'(0));
    chk("rst_addr", 256'(out_cmd_addr), 256'(0));
    @(posedge dram_clk);
    #1 dram_rst = 1'b0;
    @(posedge dram_clk);
    #1 chk("ack_after_release", 256'(in_cmd_ack), 256'(1));

    // Table vectors: single write, latency, push+pop, stall, empty
    for (int unsigned i = 0; i < 9; i++) begin
      cyc(vecs[i].v, vecs[i].a, vecs[i].r, data_of(vecs[i].a), vecs[i].b, vecs[i].rdy);
      chk($sformatf("vec%0d_fill", i), 256'(fill_level), 256'(vecs[i].exp_fill));
      chk($sformatf("vec%0d_valid", i), 256'(out_cmd_valid), 256'(vecs[i].exp_valid));
    end

    // Fill with controller stalled: ack threshold, full, full+pop, drop
    for (int unsigned i = 0; i < 13; i++) push_rand(i[0], 1'b0);
    chk("ack_at_13", 256'(in_cmd_ack), 256'(1));
    push_rand(1'b0, 1'b0);
    chk("ack_at_14", 256'(in_cmd_ack), 256'(0));
    chk("fill_14", 256'(fill_level), 256'(14));
    chk("ovf_at_14", 256'(overflow), 256'(0));
    push_rand(1'b1, 1'b0);
    push_rand(1'b0, 1'b0);
    chk("fill_16", 256'(fill_level), 256'(16));
    push_rand(1'b1, 1'b1);
    chk("full_pushpop_fill", 256'(fill_level), 256'(16));
    chk("full_pushpop_ovf", 256'(overflow), 256'(0));
    push_rand(1'b0, 1'b0);
    chk("drop_ovf", 256'(overflow), 256'(1));
    chk("drop_fill", 256'(fill_level), 256'(16));
    pulses = 0;
    for (int unsigned i = 0; i < 18; i++) idle(1'b1);
    chk("drain_pulses", 256'(pulses), 256'(16));
    chk("drain_empty", 256'(sb_q.size()), 256'(0));

    // Streaming with alternating read/write
    pulses = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      push_rand(i[0], 1'b1);
      if (fill_level > 1) chk("stream_fill_le1", 256'(fill_level), 256'(1));
    end
    idle(1'b1);
    idle(1'b1);
    chk("stream_pulses", 256'(pulses), 256'(100));

    // Reset with queued commands
    for (int unsigned i = 0; i < 6; i++) push_rand(1'b0, 1'b0);
    idle(1'b1);
    chk("pre_rst_valid", 256'(out_cmd_valid), 256'(1));
    #2 dram_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 256'(out_cmd_valid), 256'(0));
    chk("mid_rst_fill", 256'(fill_level), 256'(0));
    chk("mid_rst_ack", 256'(in_cmd_ack), 256'(0));
    chk("mid_rst_ovf", 256'(overflow), 256'(0));
    sb_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    last_out = '0;
    @(posedge dram_clk);
    #1 dram_rst = 1'b0;
    pulses = 0;
    for (int unsigned i = 0; i < 8; i++) idle(1'b1);
    chk("post_rst_pulses", 256'(pulses), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
